// File: rtl/axi4l_to_apb_bridge_if.sv
// Bus bundle between the AXI4-Lite requester, the bridge and the downstream APB slave.
// The bridge uses the slave modport (AXI slave side, APB master side).
interface axi4l_to_apb_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  in_awvalid, in_awready;
  logic [ADDR_W-1:0]     in_awaddr;
  logic [2:0]            in_awprot;
  logic                  in_wvalid, in_wready;
  logic [DATA_W-1:0]     in_wdata;
  logic [DATA_W/8-1:0]   in_wstrb;
  logic                  in_bvalid, in_bready;
  logic [1:0]            in_bresp;
  logic                  in_arvalid, in_arready;
  logic [ADDR_W-1:0]     in_araddr;
  logic [2:0]            in_arprot;
  logic                  in_rvalid, in_rready;
  logic [DATA_W-1:0]     in_rdata;
  logic [1:0]            in_rresp;
  logic                  out_psel, out_penable, out_pwrite;
  logic [ADDR_W-1:0]     out_paddr;
  logic [2:0]            out_pprot;
  logic [DATA_W-1:0]     out_pwdata;
  logic [DATA_W/8-1:0]   out_pstrb;
  logic                  out_pready, out_pslverr;
  logic [DATA_W-1:0]     out_prdata;

  modport slave (
    input  in_awvalid, in_awaddr, in_awprot, in_wvalid, in_wdata, in_wstrb, in_bready,
           in_arvalid, in_araddr, in_arprot, in_rready, out_pready, out_pslverr, out_prdata,
    output in_awready, in_wready, in_bvalid, in_bresp, in_arready, in_rvalid, in_rdata,
           in_rresp, out_psel, out_penable, out_pwrite, out_paddr, out_pprot, out_pwdata,
           out_pstrb
  );

  modport master (
    output in_awvalid, in_awaddr, in_awprot, in_wvalid, in_wdata, in_wstrb, in_bready,
           in_arvalid, in_araddr, in_arprot, in_rready, out_pready, out_pslverr, out_prdata,
    input  in_awready, in_wready, in_bvalid, in_bresp, in_arready, in_rvalid, in_rdata,
           in_rresp, out_psel, out_penable, out_pwrite, out_paddr, out_pprot, out_pwdata,
           out_pstrb
  );
endinterface

// File: rtl/axi4l_to_apb_bridge.sv
// Single-outstanding AXI4-Lite slave to APB master bridge with wait states, PSLVERR and a hang timeout.
// Handshake: a transfer happens on a rising edge where valid and ready are both high; valid never waits on ready.
module axi4l_to_apb_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                  clock,
  input  logic                  reset,
  axi4l_to_apb_bridge_if.slave  bus,
  output logic [1:0]            o_dbg_state
);
  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]        r_state;
  logic              r_aw_held, r_w_held, r_ar_held, r_last_was_write;
  logic [ADDR_W-1:0] r_awaddr, r_araddr;
  logic [2:0]        r_awprot, r_arprot;
  logic [DATA_W-1:0] r_wdata;
  logic [STRB_W-1:0] r_wstrb;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_psel, r_penable, r_pwrite, r_bvalid, r_rvalid;
  logic [ADDR_W-1:0] r_paddr;
  logic [2:0]        r_pprot;
  logic [DATA_W-1:0] r_pwdata, r_rdata;
  logic [STRB_W-1:0] r_pstrb;
  logic [1:0]        r_bresp, r_rresp;

  logic w_awready, w_wready, w_arready, w_aw_hs, w_w_hs, w_ar_hs;
  logic w_wr_pend, w_rd_pend, w_sel_rd, w_sel_wr, w_timeout, w_done;
  logic [1:0]        w_resp;
  logic [ADDR_W-1:0] w_awaddr, w_araddr;
  logic [2:0]        w_awprot, w_arprot;
  logic [DATA_W-1:0] w_wdata;
  logic [STRB_W-1:0] w_wstrb;

  assign w_awready = ~r_aw_held & ~reset;
  assign w_wready  = ~r_w_held & ~reset;
  assign w_arready = ~r_ar_held & ~reset;
  assign w_aw_hs   = bus.in_awvalid & w_awready;
  assign w_w_hs    = bus.in_wvalid & w_wready;
  assign w_ar_hs   = bus.in_arvalid & w_arready;

  // A request that handshakes this cycle is usable immediately, so bypass the holding register.
  assign w_awaddr = r_aw_held ? r_awaddr : bus.in_awaddr;
  assign w_awprot = r_aw_held ? r_awprot : bus.in_awprot;
  assign w_wdata  = r_w_held  ? r_wdata  : bus.in_wdata;
  assign w_wstrb  = r_w_held  ? r_wstrb  : bus.in_wstrb;
  assign w_araddr = r_ar_held ? r_araddr : bus.in_araddr;
  assign w_arprot = r_ar_held ? r_arprot : bus.in_arprot;

  assign w_wr_pend = (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);
  assign w_rd_pend = r_ar_held | w_ar_hs;
  // Round robin: a read wins a tie unless the last serviced transfer was a read.
  assign w_sel_rd  = (r_state == S_IDLE) & w_rd_pend & (~w_wr_pend | r_last_was_write);
  assign w_sel_wr  = (r_state == S_IDLE) & w_wr_pend & ~w_sel_rd;

  assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_LAST);
  assign w_done    = bus.out_pready | w_timeout;
  assign w_resp    = (bus.out_pready ? bus.out_pslverr : 1'b1) ? 2'b10 : 2'b00;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_aw_held <= 1'b0; r_w_held <= 1'b0; r_ar_held <= 1'b0;
      r_last_was_write <= 1'b1;
      r_awaddr <= '0; r_awprot <= '0; r_wdata <= '0; r_wstrb <= '0;
      r_araddr <= '0; r_arprot <= '0; r_cnt <= '0;
      r_psel <= 1'b0; r_penable <= 1'b0; r_pwrite <= 1'b0;
      r_paddr <= '0; r_pprot <= '0; r_pwdata <= '0; r_pstrb <= '0;
      r_bvalid <= 1'b0; r_bresp <= '0; r_rvalid <= 1'b0; r_rresp <= '0; r_rdata <= '0;
    end else begin
      if (w_aw_hs) begin r_awaddr <= bus.in_awaddr; r_awprot <= bus.in_awprot; end
      if (w_w_hs)  begin r_wdata <= bus.in_wdata; r_wstrb <= bus.in_wstrb; end
      if (w_ar_hs) begin r_araddr <= bus.in_araddr; r_arprot <= bus.in_arprot; end
      if (w_sel_wr) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
      end else begin
        if (w_aw_hs) r_aw_held <= 1'b1;
        if (w_w_hs)  r_w_held  <= 1'b1;
      end
      if (w_sel_rd)     r_ar_held <= 1'b0;
      else if (w_ar_hs) r_ar_held <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_sel_rd | w_sel_wr) begin
            r_psel           <= 1'b1;
            r_pwrite         <= w_sel_wr;
            r_paddr          <= w_sel_wr ? w_awaddr : w_araddr;
            r_pprot          <= w_sel_wr ? w_awprot : w_arprot;
            r_pwdata         <= w_sel_wr ? w_wdata : '0;
            r_pstrb          <= w_sel_wr ? w_wstrb : '0;
            r_last_was_write <= w_sel_wr;
            r_state          <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_penable <= 1'b1;
          r_cnt     <= '0;
          r_state   <= S_ACCESS;
        end
        S_ACCESS: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_done) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_state   <= S_RESP;
            if (r_pwrite) begin
              r_bvalid <= 1'b1;
              r_bresp  <= w_resp;
            end else begin
              r_rvalid <= 1'b1;
              r_rresp  <= w_resp;
              r_rdata  <= bus.out_pready ? bus.out_prdata : '0;
            end
          end
        end
        default: begin
          if ((r_bvalid & bus.in_bready) | (r_rvalid & bus.in_rready)) begin
            r_bvalid <= 1'b0;
            r_rvalid <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.in_awready  = w_awready;
  assign bus.in_wready   = w_wready;
  assign bus.in_arready  = w_arready;
  assign bus.in_bvalid   = r_bvalid;
  assign bus.in_bresp    = r_bresp;
  assign bus.in_rvalid   = r_rvalid;
  assign bus.in_rresp    = r_rresp;
  assign bus.in_rdata    = r_rdata;
  assign bus.out_psel    = r_psel;
  assign bus.out_penable = r_penable;
  assign bus.out_pwrite  = r_pwrite;
  assign bus.out_paddr   = r_paddr;
  assign bus.out_pprot   = r_pprot;
  assign bus.out_pwdata  = r_pwdata;
  assign bus.out_pstrb   = r_pstrb;
  assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_axi4l_to_apb_bridge.sv
// Bench for axi4l_to_apb_bridge: directed scenarios plus randomized traffic against a
// transaction-level model of expected APB transfers, responses and latencies.
module tb_axi4l_to_apb_bridge;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic       clock, reset;
  logic [1:0] dbg_state;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_err = 0;

  axi4l_to_apb_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  axi4l_to_apb_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .bus(bus), .o_dbg_state(dbg_state)
  );

  // APB slave knobs
  int          wait_n = 0;
  logic        hang = 1'b0;
  logic        slave_err = 1'b0;
  logic [31:0] slave_rdata = '0;

  int          acc_cnt = 0, acc_len = 0, setup_cnt = 0, resp_cnt = 0;
  logic        prev_setup = 1'b0;
  logic [71:0] setup_snap = '0;
  logic [71:0] exp_q[$];
  logic [71:0] obs_q[$];

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] apb_fields();
    return {bus.out_pwrite, bus.out_pprot, bus.out_pstrb, bus.out_paddr, bus.out_pwdata};
  endfunction

  // APB slave model and protocol monitor
  always @(negedge clock) begin
    if (bus.out_psel && bus.out_penable) acc_cnt++;
    else acc_cnt = 0;
    if (acc_cnt > 0) acc_len = acc_cnt;
    bus.out_pready  = (acc_cnt > wait_n) && !hang;
    bus.out_pslverr = bus.out_pready && slave_err;
    bus.out_prdata  = bus.out_pready ? slave_rdata : $urandom;
    if (prev_setup) check("setup_then_access", {bus.out_psel, bus.out_penable}, 2'b11);
    if (bus.out_psel && !bus.out_penable) begin
      setup_snap = apb_fields();
      setup_cnt++;
      check("setup_during_resp", bus.in_rvalid | bus.in_bvalid, 1'b0);
    end
    if (bus.out_psel && bus.out_penable) check("apb_stable", apb_fields(), setup_snap);
    if (bus.out_psel && bus.out_penable && bus.out_pready) obs_q.push_back(apb_fields());
    if ((bus.in_rvalid && bus.in_rready) || (bus.in_bvalid && bus.in_bready)) resp_cnt++;
    prev_setup = bus.out_psel && !bus.out_penable;
  end

  // driver tasks: start and end at a falling edge
  task automatic issue_ar(input logic [31:0] a, input logic [2:0] p, output int hs);
    bit done = 0;
    hs = 0;
    bus.in_araddr = a;
    bus.in_arprot = p;
    for (int k = 0; k < 50 && !done; k++) begin
      bus.in_arvalid = 1'b1;
      if (bus.in_arready) begin done = 1; hs = cyc; end
      @(negedge clock);
    end
    bus.in_arvalid = 1'b0;
    if (!done) check("ar_accept_expired", 1'b0, 1'b1);
  endtask

  task automatic issue_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [2:0] p, input int skew, output int hs);
    bit aw_done = 0, w_done = 0;
    int aw_start = (skew < 0) ? -skew : 0;
    int w_start  = (skew > 0) ? skew : 0;
    hs = 0;
    bus.in_awaddr = a; bus.in_awprot = p;
    bus.in_wdata  = d; bus.in_wstrb  = s;
    for (int k = 0; k < 50 && !(aw_done && w_done); k++) begin
      bus.in_awvalid = !aw_done && (k >= aw_start);
      bus.in_wvalid  = !w_done && (k >= w_start);
      if (bus.in_awvalid && bus.in_awready) begin aw_done = 1; hs = cyc; end
      if (bus.in_wvalid && bus.in_wready)   begin w_done = 1; hs = cyc; end
      @(negedge clock);
    end
    bus.in_awvalid = 1'b0;
    bus.in_wvalid  = 1'b0;
    if (!(aw_done && w_done)) check("wr_accept_expired", 1'b0, 1'b1);
  endtask

  task automatic wait_resp(input bit is_wr, input logic [1:0] e_resp, input logic [31:0] e_data,
                           input int hs, input int e_lat, input int bp);
    int t = 0;
    while (!(is_wr ? bus.in_bvalid : bus.in_rvalid) && t < 300) begin
      @(negedge clock);
      t++;
    end
    if (!(is_wr ? bus.in_bvalid : bus.in_rvalid)) begin
      check("resp_wait_expired", 1'b0, 1'b1);
    end else begin
      if (e_lat >= 0) check("latency", cyc - hs, e_lat);
      check("resp_apb_idle", {bus.out_psel, bus.out_penable}, 2'b00);
      check("other_valid", is_wr ? bus.in_rvalid : bus.in_bvalid, 1'b0);
      for (int i = 0; i <= bp; i++) begin
        if (i > 0) @(negedge clock);
        check("valid_held", is_wr ? bus.in_bvalid : bus.in_rvalid, 1'b1);
        if (is_wr) check("bresp", bus.in_bresp, e_resp);
        else       check("rresp_rdata", {bus.in_rresp, bus.in_rdata}, {e_resp, e_data});
      end
      if (is_wr) bus.in_bready = 1'b1; else bus.in_rready = 1'b1;
      @(negedge clock);
      bus.in_bready = 1'b0;
      bus.in_rready = 1'b0;
      check("valid_clear", {bus.in_bvalid, bus.in_rvalid}, 2'b00);
    end
  endtask

  task automatic check_xfer(input string tag);
    if (obs_q.size() == 0 || exp_q.size() == 0) check({tag, "_missing"}, obs_q.size(), exp_q.size());
    else check(tag, obs_q.pop_front(), exp_q.pop_front());
  endtask

  initial begin : main
    int hs, s_cnt, base, t, skew, bp;
    bit wr;
    logic [31:0] a, d;
    logic [3:0]  s;
    logic [2:0]  p;

    reset = 1'b1;
    bus.in_awvalid = 0; bus.in_awaddr = '0; bus.in_awprot = '0;
    bus.in_wvalid = 0;  bus.in_wdata = '0;  bus.in_wstrb = '0;  bus.in_bready = 0;
    bus.in_arvalid = 0; bus.in_araddr = '0; bus.in_arprot = '0; bus.in_rready = 0;
    repeat (3) @(negedge clock);
    check("rst_apb", {bus.out_psel, bus.out_penable, bus.out_pwrite, bus.out_pprot,
                      bus.out_pstrb, bus.out_paddr, bus.out_pwdata}, '0);
    check("rst_axi", {bus.in_bvalid, bus.in_bresp, bus.in_rvalid, bus.in_rresp, bus.in_rdata}, '0);
    check("rst_ready", {bus.in_awready, bus.in_wready, bus.in_arready}, 3'b000);
    check("rst_state", dbg_state, 2'd0);
    reset = 1'b0;
    @(negedge clock);
    check("ready_after_rst", {bus.in_awready, bus.in_wready, bus.in_arready}, 3'b111);

    // round robin: read and write pending together, twice
    bus.in_rready = 1'b1; bus.in_bready = 1'b1;
    for (int it = 0; it < 2; it++) begin
      base = resp_cnt;
      a = 32'h2000_0000 + it * 16;
      bus.in_araddr = a; bus.in_arprot = 3'b001; bus.in_arvalid = 1'b1;
      bus.in_awaddr = a + 4; bus.in_awprot = 3'b010; bus.in_awvalid = 1'b1;
      bus.in_wdata = 32'hC0DE_0000 + it; bus.in_wstrb = 4'hF; bus.in_wvalid = 1'b1;
      exp_q.push_back({1'b0, 3'b001, 4'h0, a, 32'h0});
      exp_q.push_back({1'b1, 3'b010, 4'hF, a + 32'd4, 32'hC0DE_0000 + it});
      check("rr_ready", {bus.in_awready, bus.in_wready, bus.in_arready}, 3'b111);
      @(negedge clock);
      bus.in_arvalid = 0; bus.in_awvalid = 0; bus.in_wvalid = 0;
      t = 0;
      while (resp_cnt < base + 2 && t < 60) begin @(negedge clock); t++; end
      check("rr_resp_count", resp_cnt - base, 2);
    end
    bus.in_rready = 1'b0; bus.in_bready = 1'b0;
    for (int i = 0; i < 4; i++) check_xfer("rr_order");

    // zero-wait write, AW and W together
    exp_q.push_back({1'b1, 3'b000, 4'b1000, 32'h1000_0003, 32'h5A00_0000});
    issue_wr(32'h1000_0003, 32'h5A00_0000, 4'b1000, 3'b000, 0, hs);
    wait_resp(1, 2'b00, '0, hs, 3, 0);
    check_xfer("wr_zero_wait");
    check("wr_acc_len", acc_len, 1);

    // read with three wait states
    wait_n = 3; slave_rdata = 32'h6060_6060;
    exp_q.push_back({1'b0, 3'b000, 4'h0, 32'h1000_0005, 32'h0});
    issue_ar(32'h1000_0005, 3'b000, hs);
    wait_resp(0, 2'b00, 32'h6060_6060, hs, 6, 0);
    check_xfer("rd_wait3");
    check("rd_acc_len", acc_len, 4);
    wait_n = 0;

    // PSLVERR on a write
    slave_err = 1'b1;
    exp_q.push_back({1'b1, 3'b101, 4'h3, 32'h1000_0040, 32'h1234_5678});
    issue_wr(32'h1000_0040, 32'h1234_5678, 4'h3, 3'b101, 1, hs);
    wait_resp(1, 2'b10, '0, hs, 3, 1);
    check_xfer("wr_slverr");
    slave_err = 1'b0;

    // dead slave: read times out after TO access cycles
    hang = 1'b1;
    issue_ar(32'h1000_0080, 3'b000, hs);
    wait_resp(0, 2'b10, '0, hs, 2 + TO, 0);
    check("to_acc_len", acc_len, TO);
    check("to_no_xfer", obs_q.size(), 0);
    hang = 1'b0;

    // back-pressure on R with a second AR arriving meanwhile
    slave_rdata = 32'hA5A5_0001;
    exp_q.push_back({1'b0, 3'b000, 4'h0, 32'h3000_0000, 32'h0});
    issue_ar(32'h3000_0000, 3'b000, hs);
    t = 0;
    while (!bus.in_rvalid && t < 50) begin @(negedge clock); t++; end
    s_cnt = setup_cnt;
    bus.in_araddr = 32'h3000_0010; bus.in_arprot = 3'b011; bus.in_arvalid = 1'b1;
    check("bp_arready_open", bus.in_arready, 1'b1);
    @(negedge clock);
    bus.in_arvalid = 1'b0;
    check("bp_ar_held", bus.in_arready, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("bp_r_stable", {bus.in_rvalid, bus.in_rresp, bus.in_rdata}, {1'b1, 2'b00, 32'hA5A5_0001});
    end
    check("bp_no_setup", setup_cnt, s_cnt);
    check_xfer("bp_first");
    exp_q.push_back({1'b0, 3'b011, 4'h0, 32'h3000_0010, 32'h0});
    slave_rdata = 32'h0BAD_F00D;
    bus.in_rready = 1'b1;
    @(negedge clock);
    bus.in_rready = 1'b0;
    wait_resp(0, 2'b00, 32'h0BAD_F00D, 0, -1, 0);
    check_xfer("bp_second");
    check("bp_one_setup", setup_cnt, s_cnt + 1);

    // reset during ACCESS
    hang = 1'b1;
    issue_ar(32'h4000_0000, 3'b000, hs);
    t = 0;
    while (!(bus.out_psel && bus.out_penable) && t < 20) begin @(negedge clock); t++; end
    check("rst_mid_in_access", {bus.out_psel, bus.out_penable}, 2'b11);
    reset = 1'b1;
    @(negedge clock);
    check("rst_mid_apb", {bus.out_psel, bus.out_penable}, 2'b00);
    check("rst_mid_resp", {bus.in_rvalid, bus.in_bvalid}, 2'b00);
    check("rst_mid_ready", {bus.in_awready, bus.in_wready, bus.in_arready}, 3'b000);
    reset = 1'b0; hang = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("rst_mid_no_resp", {bus.in_rvalid, bus.in_bvalid, bus.out_psel}, 3'b000);
    end
    exp_q.push_back({1'b1, 3'b000, 4'hF, 32'h4000_0004, 32'hFEED_BEEF});
    issue_wr(32'h4000_0004, 32'hFEED_BEEF, 4'hF, 3'b000, -1, hs);
    wait_resp(1, 2'b00, '0, hs, 3, 0);
    check_xfer("after_rst_wr");

    // randomized single-outstanding traffic
    for (int n = 0; n < 40; n++) begin
      wr = 1'($urandom_range(0, 1));
      a = $urandom; d = $urandom;
      s = 4'($urandom_range(0, 15)); p = 3'($urandom_range(0, 7));
      wait_n = int'($urandom_range(0, 3));
      slave_err = ($urandom_range(0, 3) == 0);
      slave_rdata = $urandom;
      skew = int'($urandom_range(0, 4)) - 2;
      bp = int'($urandom_range(0, 2));
      if (wr) begin
        exp_q.push_back({1'b1, p, s, a, d});
        issue_wr(a, d, s, p, skew, hs);
        wait_resp(1, slave_err ? 2'b10 : 2'b00, '0, hs, 3 + wait_n, bp);
      end else begin
        exp_q.push_back({1'b0, p, 4'h0, a, 32'h0});
        issue_ar(a, p, hs);
        wait_resp(0, slave_err ? 2'b10 : 2'b00, slave_rdata, hs, 3 + wait_n, bp);
      end
      check_xfer("rand_xfer");
      check("rand_acc_len", acc_len, wait_n + 1);
      slave_err = 1'b0;
    end

    check("leftover_xfers", exp_q.size() + obs_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/axi4l_to_apb_bridge.md
Name: axi4l_to_apb_bridge

Overview:
- Single-outstanding bridge: converts AXI4-Lite slave transactions into APB3/APB4 master transfers.
- Sits directly upstream of the UART16550 APB wrapper and other APB peripherals in the SoC peripheral path.
- Its `out_*` APB master ports connect straight to the peripheral's `in_*` APB slave ports.
- Supports APB wait states, PSLVERR propagation, and a hang timeout so a dead slave cannot lock the bus.

Parameters:
- ADDR_W, 32, address width on both sides.
- DATA_W, 32, data width; PSTRB width is DATA_W/8.
- TIMEOUT, 256, max ACCESS cycles with PREADY low before forced SLVERR completion; 0 disables the timeout.

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- in_awvalid/in_awready  in/out  1  AXI write-address handshake.
- in_awaddr  in  ADDR_W  write address.
- in_awprot  in  3  write protection bits.
- in_wvalid/in_wready  in/out  1  AXI write-data handshake.
- in_wdata  in  DATA_W  write data.
- in_wstrb  in  DATA_W/8  write byte strobes.
- in_bvalid/in_bready  out/in  1  AXI write-response handshake.
- in_bresp  out  2  write response.
- in_arvalid/in_arready  in/out  1  AXI read-address handshake.
- in_araddr  in  ADDR_W  read address.
- in_arprot  in  3  read protection bits.
- in_rvalid/in_rready  out/in  1  AXI read-data handshake.
- in_rdata  out  DATA_W  read data.
- in_rresp  out  2  read response.
- out_psel, out_penable, out_pwrite  out  1  APB control.
- out_paddr  out  ADDR_W  APB address.
- out_pprot  out  3  APB protection.
- out_pwdata  out  DATA_W  APB write data.
- out_pstrb  out  DATA_W/8  APB write strobes.
- out_pready, out_pslverr  in  1  APB completion and error.
- out_prdata  in  DATA_W  APB read data.

Behaviour:
- Clock/reset: one clock, `clock`; reset is synchronous and active-high on `reset`.
- Reset values:
  - All registered outputs clear to 0: psel, penable, pwrite, paddr, pprot, pwdata, pstrb, bvalid, bresp, rvalid, rresp, rdata.
  - Holding flags are cleared and the FSM goes to IDLE.
  - awready/wready/arready are 0 while reset is high.
- Reset mid-transfer: APB is abandoned immediately (psel/penable drop next edge); no AXI response is issued.
- Holding registers: three independent ones (AW, W, AR).
  - in_awready = ~aw_held & ~reset; same rule for wready and arready.
  - Readies are therefore independent of FSM state; AW and W may arrive in either order or in the same cycle.
- Pending conditions:
  - Write pending = (aw_held | aw handshake this cycle) & (w_held | w handshake this cycle).
  - Read pending = ar_held | ar handshake this cycle.
- FSM: IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
- IDLE:
  - Only read pending: select the read. Only write pending: select the write.
  - Both pending: round-robin using last_was_write. After reset, read wins first; thereafter the opposite of the last serviced type wins.
  - On selection: load paddr, pprot, pwrite, pwdata/pstrb (pstrb=0 and pwdata=0 for reads); clear the consumed holding flags; go to SETUP.
- SETUP: psel=1, penable=0, for exactly one cycle; go to ACCESS.
- ACCESS: psel=1, penable=1; the timeout counter increments each cycle.
  - On out_pready=1: capture prdata (reads) and pslverr; drop psel/penable; go to RESP.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT with pready still low: drop psel/penable; go to RESP with SLVERR; rdata=0.
  - The counter clears on entering ACCESS.
- RESP:
  - Assert rvalid (read) or bvalid (write).
  - resp = 2'b10 on pslverr or timeout, else 2'b00.
  - Hold data/resp stable until rready/bready; then go to IDLE.
  - pready sampled in ACCESS is never re-sampled here.
- Latency, zero-wait slave:
  - AR handshake at cycle C: SETUP at C+1, ACCESS at C+2, rvalid at C+3.
  - Each APB wait state adds one cycle.
  - Write latency is measured from the later of the AW/W handshakes.
- Strict ordering: at most one APB transfer in flight; no new SETUP until the current response handshakes.
- APB rules: paddr/pwrite/pwdata/pstrb/pprot stay stable from SETUP through the final ACCESS cycle; psel never deasserts between SETUP and ACCESS.

Test Plan:
- Write, zero-wait: AW+W same cycle, addr 0x1000_0003, wdata 0x5A000000, wstrb 4'b1000 -> SETUP next cycle, then one ACCESS with pwrite=1, pstrb=1000; bvalid 3 cycles after handshake, bresp=00.
- Read with 3 APB wait states: araddr 0x1000_0005, slave returns 0x60606060 -> rvalid at C+6, rdata=0x60606060, rresp=00.
- Read and write pending in the same cycle, twice in succession, after reset -> read issued first, then write, then read, then write (round-robin).
- PSLVERR=1 on a write, and separately TIMEOUT=8 with pready tied low on a read -> bresp=10; read completes after 8 ACCESS cycles with rresp=10, rdata=0, psel dropped.
- Back-pressure: rready held low 5 cycles, new AR presented meanwhile -> rdata stable; AR accepted into hold (arready drops); no SETUP until rready.
- Reset asserted during ACCESS -> psel/penable=0 next edge; no rvalid/bvalid; next transaction completes normally.
